// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: panel HSYNC/VSYNC/DE and active x/y generator.
// Ports: clk, rst_n, en -> hsync, vsync, de, x, y, line_start,
//   frame_start, rgb. Macro LCD_TIMING_TEST_PATTERN_EN enables
//   8-bar colour test pattern on rgb (otherwise rgb tied 0).
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [23:0]   rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [XW-1:0] r_h_cnt;
  logic [YW-1:0] r_v_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_ls;
  logic          r_fs;

  logic w_h_end;
  logic w_v_end;
  logic w_de;
  logic w_hs_act;
  logic w_vs_act;
  logic w_ls;
  logic w_fs;

  assign w_h_end  = (r_h_cnt == XW'(H_TOTAL - 1));
  assign w_v_end  = (r_v_cnt == YW'(V_TOTAL - 1));
  assign w_de     = (r_h_cnt < XW'(H_ACTIVE)) &&
                    (r_v_cnt < YW'(V_ACTIVE));
  assign w_hs_act = (r_h_cnt >= XW'(HS_BEG)) &&
                    (r_h_cnt <  XW'(HS_END));
  assign w_vs_act = (r_v_cnt >= YW'(VS_BEG)) &&
                    (r_v_cnt <  YW'(VS_END));
  assign w_ls     = w_de && (r_h_cnt == '0);
  assign w_fs     = w_ls && (r_v_cnt == '0);

  // Counters park at the frame origin while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_end ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Outputs are a registered decode of the counters, one clk behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else if (!en) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_hsync <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync <= w_vs_act ? VS_POL : ~VS_POL;
      r_de    <= w_de;
      r_ls    <= w_ls;
      r_fs    <= w_fs;
      if (w_de) begin
        r_x <= r_h_cnt;
        r_y <= r_v_cnt;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [XW-1:0] w_bar_raw;
  logic [2:0]    w_bar;
  logic [23:0]   w_rgb;
  logic [23:0]   r_rgb;

  assign w_bar_raw = r_h_cnt / XW'(BAR_W);
  // Remainder pixels when H_ACTIVE is not a multiple of 8 stay black.
  assign w_bar = (w_bar_raw > XW'(7)) ? 3'd7 : w_bar_raw[2:0];

  always_comb begin
    w_rgb = 24'h000000;
    unique case (w_bar)
      3'd0: w_rgb = 24'hFFFFFF;
      3'd1: w_rgb = 24'hFFFF00;
      3'd2: w_rgb = 24'h00FFFF;
      3'd3: w_rgb = 24'h00FF00;
      3'd4: w_rgb = 24'hFF00FF;
      3'd5: w_rgb = 24'hFF0000;
      3'd6: w_rgb = 24'h0000FF;
      3'd7: w_rgb = 24'h000000;
      default: w_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= (en && w_de) ? w_rgb : 24'h000000;
    end
  end

  assign rgb = r_rgb;
`else
  assign rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: checks lcd_timing_gen against a frame-position
// model on small timing parameters.
module tb_lcd_timing_gen;

`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam int HA = 16;
`else
  localparam int HA = 8;
`endif
  localparam int HFP = 1;
  localparam int HSW = 2;
  localparam int HBP = 1;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSW = 1;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        line_start;
  logic        frame_start;
  logic [23:0] rgb;

  int n_cmp;
  int n_err;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start),
    .rgb(rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a single position within the frame, decoded by arithmetic.
  int          pos;
  logic        e_de, e_hs, e_vs, e_ls, e_fs;
  logic [9:0]  e_x, e_y;
  logic [23:0] e_rgb;

  localparam logic [48:0] RST_VEC =
    {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 24'd0};

  function automatic logic [23:0] bar_col(int xx);
    int b;
    b = xx / (HA / 8);
    if (b > 7) b = 7;
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [48:0] obs();
    return {de, hsync, vsync, line_start, frame_start, x, y, rgb};
  endfunction

  function automatic logic [48:0] expv();
    return {e_de, e_hs, e_vs, e_ls, e_fs, e_x, e_y, e_rgb};
  endfunction

  task automatic model_reset();
    pos = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0;
    e_x = 0; e_y = 0; e_rgb = 0;
  endtask

  task automatic model_edge();
    int h, v;
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      pos = 0;
      e_de = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0; e_rgb = 0;
    end else begin
      h = pos % HT;
      v = pos / HT;
      e_de = (h < HA) && (v < VA);
      e_hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
      e_vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
      e_ls = e_de && (h == 0);
      e_fs = e_ls && (v == 0);
      if (e_de) begin
        e_x = 10'(h);
        e_y = 10'(v);
      end
`ifdef LCD_TIMING_TEST_PATTERN_EN
      e_rgb = e_de ? bar_col(h) : 24'h0;
`else
      e_rgb = 24'h0;
`endif
      pos = (pos + 1) % FT;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    en = 0;
    model_reset();
    repeat (3) tick();
    n_cmp++;
    if (obs() !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_vals: got %h want %h", obs(), RST_VEC);
    end
    rst_n = 1;
    tick();
    n_cmp++;
    if (obs() !== RST_VEC) begin
      n_err++;
      $display("FAIL idle_en_low: got %h want %h", obs(), RST_VEC);
    end
  endtask

  task automatic test_frames();
    int c_de, c_fs, c_ls, c_hs, c_vs, last_fs, bad_gap, bad;
    c_de = 0; c_fs = 0; c_ls = 0; c_hs = 0; c_vs = 0;
    last_fs = -1; bad_gap = 0; bad = 0;
    en = 1;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      if (obs() !== expv()) begin
        bad++;
        if (bad < 5)
          $display("FAIL frames_cyc%0d: got %h want %h",
                   i, obs(), expv());
      end
      c_de += int'(de);
      c_ls += int'(line_start);
      c_hs += int'(!hsync);
      c_vs += int'(!vsync);
      if (frame_start) begin
        c_fs++;
        if (last_fs >= 0 && i - last_fs != FT) bad_gap++;
        last_fs = i;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL frames_model: got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (c_de != 2 * HA * VA) begin
      n_err++;
      $display("FAIL de_count: got %0d want %0d", c_de, 2 * HA * VA);
    end
    n_cmp++;
    if (c_fs != 2 || bad_gap != 0) begin
      n_err++;
      $display("FAIL fs_count: got %0d gaps_bad %0d want 2 0",
               c_fs, bad_gap);
    end
    n_cmp++;
    if (c_ls != 2 * VA) begin
      n_err++;
      $display("FAIL ls_count: got %0d want %0d", c_ls, 2 * VA);
    end
    n_cmp++;
    if (c_hs != 2 * VT * HSW) begin
      n_err++;
      $display("FAIL hs_count: got %0d want %0d", c_hs, 2 * VT * HSW);
    end
    n_cmp++;
    if (c_vs != 2 * VSW * HT) begin
      n_err++;
      $display("FAIL vs_count: got %0d want %0d", c_vs, 2 * VSW * HT);
    end
  endtask

  task automatic test_abort();
    int guard;
    guard = 0;
    en = 1;
    // Advance until the counters sit at h=5, v=2.
    while (pos != 2 * HT + 5 && guard < 2 * FT) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (pos != 2 * HT + 5) begin
      n_err++;
      $display("FAIL abort_reach: got pos %0d want %0d", pos, 2 * HT + 5);
    end
    en = 0;
    tick();
    n_cmp++;
    if ({de, hsync, vsync, line_start, frame_start} !== 5'b01100) begin
      n_err++;
      $display("FAIL abort_idle: got %b want 01100",
               {de, hsync, vsync, line_start, frame_start});
    end
    tick();
    tick();
    n_cmp++;
    if (obs() !== expv()) begin
      n_err++;
      $display("FAIL abort_hold: got %h want %h", obs(), expv());
    end
    en = 1;
    tick();
    n_cmp++;
    if ({de, frame_start, line_start, x, y} !== {3'b111, 20'd0}) begin
      n_err++;
      $display("FAIL restart_fs: got de%b fs%b ls%b x%0d y%0d want 1 1 1 0 0",
               de, frame_start, line_start, x, y);
    end
    for (int i = 0; i < FT; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL restart_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random_en();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 15) != 0);
      tick();
      if (obs() !== expv()) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rand_en: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int guard, bad, c_fs;
    guard = 0; bad = 0; c_fs = 0;
    en = 1;
    while (!(e_hs == 0 && e_vs == 0) && guard < 2 * FT) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (obs() !== expv() || hsync !== 1'b0 || vsync !== 1'b0) begin
      n_err++;
      $display("FAIL in_sync: got %h want %h", obs(), expv());
    end
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs() !== RST_VEC) begin
      n_err++;
      $display("FAIL async_rst: got %h want %h", obs(), RST_VEC);
    end
    model_reset();
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < FT + HT; i++) begin
      tick();
      if (i < FT) c_fs += int'(frame_start);
      if (obs() !== expv()) begin
        bad++;
        if (bad < 5)
          $display("FAIL post_rst_cyc%0d: got %h want %h",
                   i, obs(), expv());
      end
      if (i == 0) begin
        n_cmp++;
        if (frame_start !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin
          n_err++;
          $display("FAIL post_rst_fs: got fs%b x%0d y%0d want 1 0 0",
                   frame_start, x, y);
        end
      end
    end
    n_cmp++;
    if (bad != 0 || c_fs != 1) begin
      n_err++;
      $display("FAIL post_rst: got %0d bad, %0d fs want 0, 1", bad, c_fs);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 0;
    en = 0;
    model_reset();
    test_reset();
    test_frames();
    test_abort();
    test_random_en();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
